// File: rtl/vexp_seq_bf16.sv
// vexp_seq_bf16: vector sequencer for the bf16 exponential unit.
// Latches a vector, resolves masked and special-value lanes locally, issues
// the rest one at a time to the single-element exp FSM, and hands the
// collected result vector downstream with a valid/ready handshake.
module vexp_seq_bf16 #(
  parameter int VLEN    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic                start_ready,
  input  logic [16*VLEN-1:0]  vec_in,
  input  logic [VLEN-1:0]     mask_in,
  output logic [15:0]         exp_operand,
  output logic                exp_valid_in,
  input  logic [15:0]         exp_result,
  input  logic                exp_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*VLEN-1:0]  vec_out,
  output logic                out_err
);

  localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] QNAN = 16'h7FC0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  state_t             state, state_d;
  logic [IW-1:0]      idx;
  logic [WW-1:0]      wdog;
  logic [16*VLEN-1:0] vec_q;
  logic [VLEN-1:0]    mask_q;

  logic [15:0]        elem;
  logic               is_last;
  logic               timeout_hit;
  logic               loc_hit;
  logic [15:0]        loc_val;
  logic               res_we;
  logic [15:0]        res_val;
  logic               set_err;
  logic               adv;

  assign elem        = vec_q[16*idx +: 16];
  assign is_last     = (idx == IW'(VLEN - 1));
  assign timeout_hit = (wdog == WW'(TIMEOUT - 1));

  // Classify the current element: masked lanes and special values resolve here.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    loc_hit = 1'b1;
    loc_val = elem;
    if (!mask_q[idx])                loc_val = elem;
    else if (elem[14:7] == 8'h00)    loc_val = 16'h3F80;  // +-0 and subnormals: exp(0) = 1
    else if (elem == 16'h7F80)       loc_val = 16'h7F80;  // +inf
    else if (elem == 16'hFF80)       loc_val = 16'h0000;  // -inf
    else if (elem[14:7] == 8'hFF)    loc_val = QNAN;      // NaN; infinities matched above
    else                             loc_hit = 1'b0;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d      = state;
    res_we       = 1'b0;
    res_val      = '0;
    set_err      = 1'b0;
    adv          = 1'b0;
    exp_valid_in = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_d = S_ISSUE;
      S_ISSUE: begin
        if (loc_hit) begin
          res_we  = 1'b1;
          res_val = loc_val;
          adv     = 1'b1;
          state_d = is_last ? S_OUTPUT : S_ISSUE;
        end else begin
          exp_valid_in = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done in the watchdog's final cycle takes priority over the timeout.
        if (exp_done) begin
          res_we  = 1'b1;
          res_val = exp_result;
          adv     = 1'b1;
          state_d = is_last ? S_OUTPUT : S_ISSUE;
        end else if (timeout_hit) begin
          res_we  = 1'b1;
          res_val = QNAN;
          set_err = 1'b1;
          adv     = 1'b1;
          state_d = is_last ? S_OUTPUT : S_ISSUE;
        end
      end
      S_OUTPUT: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign start_ready = (state == S_IDLE);
  assign out_valid   = (state == S_OUTPUT);
  // The operand is presented with the issue pulse and held for the whole wait.
  assign exp_operand = ((state == S_ISSUE && !loc_hit) || state == S_WAIT) ? elem : 16'h0000;

  // Datapath: input latch, element index, watchdog, result vector and error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the latched vector is reset too, so the visible outputs are defined straight out of reset.
      vec_q   <= '0;
      mask_q  <= '0;
      idx     <= '0;
      wdog    <= '0;
      vec_out <= '0;
      out_err <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        vec_q   <= vec_in;
        mask_q  <= mask_in;
        idx     <= '0;
        vec_out <= '0;
        out_err <= 1'b0;
      end
      if (state == S_ISSUE)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 1'b1;
      if (res_we)               vec_out[16*idx +: 16] <= res_val;
      if (set_err)              out_err <= 1'b1;
      if (adv && !is_last)      idx <= idx + 1'b1;
    end
  end

endmodule
